// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: opcodes, functs,
// FSM states, ALU control codes and small decode helpers.
package mc_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Instruction sequencing states
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  // ALU control codes
  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7
  } alu_ctrl_e;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // True for the R-type functs this core implements (NOP included)
  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_NOP) || (funct == FN_ADD) || (funct == FN_SUB) ||
           (funct == FN_AND) || (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear. r0 reads as zero and ignores writes.
module mc_regfile
  import mc_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  // Register array: cleared on reset, written on a WB cycle unless target is r0
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: resetting a storage array maps it onto flops instead of a RAM
    // macro; done on purpose because software relies on every register
    // starting at zero after reset.
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous reads with r0 forced to zero
  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/datapath_multiciclo.sv
// Multi-cycle MIPS datapath: FETCH/DECODE/EXEC/MEM/WB sequenced by one FSM,
// sharing a single instruction/data memory port with a req/ready handshake.
// Optional build macro BNE_EN adds the bne instruction; without it the bne
// opcode is treated as illegal and halts the core.
module datapath_multiciclo
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       tr_salida_final,
  output logic              wb_valid,
  output logic              illegal
);

  // Architectural and inter-stage registers
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] tr_q, tr_d;
  logic        wb_valid_q, wb_valid_d;
  logic        illegal_q, illegal_d;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign imm_sext = sext16(imm);

  // Register file hookup: writes happen only in WB
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign rf_we    = (state_q == WB);
  assign rf_waddr = (opcode == OP_R) ? rd : rt;
  assign rf_wdata = (opcode == OP_LW) ? mdr_q : aluout_q;

  mc_regfile u_regfile (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // Opcode legality check used in DECODE
  logic op_legal;
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R:                               op_legal = funct_legal(funct);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef BNE_EN
      OP_BNE:                             op_legal = 1'b1;
`endif
      default:                            op_legal = 1'b0;
    endcase
  end

  // ALU: R-type uses B and the funct-selected op; addi/lw/sw add the immediate
  alu_ctrl_e   alu_ctrl;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_b    = imm_sext;
    if (opcode == OP_R) begin
      alu_b = b_q;
      case (funct)
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        default: alu_ctrl = ALU_ADD;
      endcase
    end
    case (alu_ctrl)
      ALU_SUB: alu_result = a_q - alu_b;
      ALU_AND: alu_result = a_q & alu_b;
      ALU_OR:  alu_result = a_q | alu_b;
      ALU_SLT: alu_result = {31'd0, ($signed(a_q) < $signed(alu_b))};
      default: alu_result = a_q + alu_b;
    endcase
  end

  // Memory port request from the FSM, before the reset gate
  logic        req_raw, we_raw;
  logic [31:0] addr_full;

  // Next-state and datapath control for every stage
  always_comb begin
    // NOTE: combinational blocks use blocking assignments, and every signal
    // gets a default first so no path can leave one unassigned (latch).
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    aluout_d   = aluout_q;
    mdr_d      = mdr_q;
    target_d   = target_q;
    tr_d       = tr_q;
    wb_valid_d = 1'b0;
    illegal_d  = illegal_q;
    req_raw    = 1'b0;
    we_raw     = 1'b0;
    addr_full  = pc_q;

    case (state_q)
      FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = DECODE;
        end
      end

      DECODE: begin
        a_d      = rf_rdata_a;
        b_d      = rf_rdata_b;
        target_d = pc_q + (imm_sext << 2);
        if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else if (opcode == OP_J) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        case (opcode)
          OP_R: begin
            if (funct == FN_NOP) begin
              state_d = FETCH;
            end else begin
              aluout_d = alu_result;
              state_d  = WB;
            end
          end
          OP_ADDI: begin
            aluout_d = alu_result;
            state_d  = WB;
          end
          OP_LW, OP_SW: begin
            aluout_d = alu_result;
            state_d  = MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = target_q;
            state_d = FETCH;
          end
`ifdef BNE_EN
          OP_BNE: begin
            if (a_q != b_q) pc_d = target_q;
            state_d = FETCH;
          end
`endif
          default: state_d = HALT;  // unreachable: DECODE filtered it
        endcase
      end

      MEM: begin
        req_raw   = 1'b1;
        we_raw    = (opcode == OP_SW);
        addr_full = aluout_q;
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = WB;
          end
        end
      end

      WB: begin
        tr_d       = rf_wdata;
        wb_valid_d = 1'b1;
        state_d    = FETCH;
      end

      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RST_N) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
      target_q   <= '0;
      tr_q       <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      aluout_q   <= aluout_d;
      mdr_q      <= mdr_d;
      target_q   <= target_d;
      tr_q       <= tr_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  // The reset gate drops the request at once, even mid-access, while the
  // state register is held in FETCH; the aborted access is never retried.
  assign mem_req         = req_raw & RST_N;
  assign mem_we          = we_raw & RST_N;
  assign mem_addr        = addr_full[ADDR_W-1:0];
  assign mem_wdata       = b_q;
  assign tr_salida_final = tr_q;
  assign wb_valid        = wb_valid_q;
  assign illegal         = illegal_q;

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Self-checking bench for datapath_multiciclo: a memory responder with
// programmable wait states, and a monitor that scoreboards every memory
// access and every register writeback against queued expectations.
module tb_datapath_multiciclo;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] tr_salida_final;
  logic        wb_valid, illegal;

  datapath_multiciclo #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .tr_salida_final (tr_salida_final),
    .wb_valid        (wb_valid),
    .illegal         (illegal)
  );

  localparam logic [31:0] ILL = 32'hFC00_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          wait_states = 0;
  int          wait_cnt    = 0;
  logic [31:0] mem [256];
  acc_t        exp_acc [$];
  logic [31:0] exp_wb  [$];
  int          acc_cyc [$];
  int          wb_cyc  [$];

  initial forever #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: decides mem_ready on the falling edge, the transfer
  // completes on the following rising edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (RST_N && mem_req) begin
        if (wait_cnt < wait_states) begin
          mem_ready = 1'b0;
          wait_cnt++;
        end else begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[9:2]];
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT writes back or completes
  // a memory access.
  initial begin
    acc_t        e;
    logic [31:0] w;
    forever begin
      @(negedge CLK);
      #1;
      if (RST_N && wb_valid) begin
        wb_cyc.push_back(cyc);
        if (exp_wb.size() == 0) begin
          check(1'b0, "wb_unexpected", tr_salida_final, 32'd0);
        end else begin
          w = exp_wb.pop_front();
          check(tr_salida_final == w, "wb_value", tr_salida_final, w);
        end
      end
      if (RST_N && mem_req && mem_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_acc.size() == 0) begin
          check(1'b0, "acc_unexpected", mem_addr, 32'd0);
        end else begin
          e = exp_acc.pop_front();
          check(mem_addr == e.addr, "acc_addr", mem_addr, e.addr);
          check(mem_we == e.we, "acc_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) check(mem_wdata == e.wdata, "acc_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  task automatic exp_fetch(input logic [31:0] a);
    exp_acc.push_back('{we: 1'b0, addr: a, wdata: 32'd0});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    exp_acc.push_back('{we: 1'b1, addr: a, wdata: d});
  endtask

  // Assert reset, verify reset outputs and that the previous test consumed
  // all its expectations, then prepare a clean memory image.
  task automatic start_test(input int ws);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #3;
    check(mem_req == 1'b0, "rst_mem_req", {31'd0, mem_req}, 32'd0);
    check(illegal == 1'b0, "rst_illegal", {31'd0, illegal}, 32'd0);
    check(tr_salida_final == 32'd0, "rst_tr", tr_salida_final, 32'd0);
    check(wb_valid == 1'b0, "rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check(exp_acc.size() == 0, "acc_missing", exp_acc.size(), 32'd0);
    check(exp_wb.size() == 0, "wb_missing", exp_wb.size(), 32'd0);
    exp_acc.delete();
    exp_wb.delete();
    acc_cyc.delete();
    wb_cyc.delete();
    for (int i = 0; i < 256; i++) mem[i] = ILL;
    wait_states = ws;
  endtask

  task automatic release_and_run(input int n);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    repeat (n) @(negedge CLK);
    #3;
  endtask

  task automatic check_halted();
    check(illegal == 1'b1, "halt_illegal", {31'd0, illegal}, 32'd1);
    check(mem_req == 1'b0, "halt_no_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic check_gap(input string name, input int i, input int j, input int exp);
    if (acc_cyc.size() > j) check(acc_cyc[j] - acc_cyc[i] == exp, name, acc_cyc[j] - acc_cyc[i], exp);
    else check(1'b0, name, acc_cyc.size(), j + 1);
  endtask

  initial begin
    bit found;

    // addi then add, no wait states, ending on an illegal opcode
    start_test(0);
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h0021_1020;  // add  $2,$1,$1
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_wb.push_back(32'd5); exp_wb.push_back(32'd10);
    release_and_run(30);
    check_halted();
    check(tr_salida_final == 32'd10, "tr_hold", tr_salida_final, 32'd10);
    check_gap("gap_addi", 0, 1, 4);
    check_gap("gap_add", 1, 2, 4);
    if (wb_cyc.size() > 1) check(wb_cyc[1] - wb_cyc[0] == 4, "wb_spacing", wb_cyc[1] - wb_cyc[0], 32'd4);
    else check(1'b0, "wb_spacing", wb_cyc.size(), 32'd2);

    // ALU op coverage, write to $0 discarded, unsupported funct halts
    start_test(0);
    mem[0] = 32'h2001_FFFD;  // addi $1,$0,-3
    mem[1] = 32'h2002_0005;  // addi $2,$0,5
    mem[2] = 32'h0022_1822;  // sub  $3,$1,$2
    mem[3] = 32'h0022_2024;  // and  $4,$1,$2
    mem[4] = 32'h0022_2825;  // or   $5,$1,$2
    mem[5] = 32'h0022_302A;  // slt  $6,$1,$2
    mem[6] = 32'h0041_382A;  // slt  $7,$2,$1
    mem[7] = 32'h0021_0020;  // add  $0,$1,$1
    mem[8] = 32'h0001_4020;  // add  $8,$0,$1
    mem[9] = 32'h0000_0021;  // funct 0x21: illegal
    for (int i = 0; i < 10; i++) exp_fetch(32'(i * 4));
    exp_wb.push_back(32'hFFFF_FFFD); exp_wb.push_back(32'd5);
    exp_wb.push_back(32'hFFFF_FFF8); exp_wb.push_back(32'd5);
    exp_wb.push_back(32'hFFFF_FFFD); exp_wb.push_back(32'd1);
    exp_wb.push_back(32'd0);         exp_wb.push_back(32'hFFFF_FFFA);
    exp_wb.push_back(32'hFFFF_FFFD);
    release_and_run(60);
    check_halted();

    // sw/lw round trip with two wait states per access
    start_test(2);
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h0021_1020;  // add  $2,$1,$1
    mem[2] = 32'hAC02_0008;  // sw   $2,8($0)
    mem[3] = 32'h8C03_0008;  // lw   $3,8($0)
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_write(32'h8, 32'd10);
    exp_fetch(32'hC); exp_fetch(32'h8); exp_fetch(32'h10);
    exp_wb.push_back(32'd5); exp_wb.push_back(32'd10); exp_wb.push_back(32'd10);
    release_and_run(80);
    check_halted();
    check(mem[2] == 32'd10, "sw_stored", mem[2], 32'd10);
    check_gap("gap_addi_ws", 0, 1, 6);
    check_gap("gap_add_ws", 1, 2, 6);
    check_gap("gap_sw_ws", 2, 4, 8);
    check_gap("gap_lw_ws", 4, 6, 9);

    // beq taken at 0x10 (after two NOPs)
    start_test(0);
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h2002_0005;  // addi $2,$0,5
    mem[2] = 32'h0000_0000;  // nop
    mem[3] = 32'h0000_0000;  // nop
    mem[4] = 32'h1022_0002;  // beq $1,$2,2
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_fetch(32'hC); exp_fetch(32'h10); exp_fetch(32'h1C);
    exp_wb.push_back(32'd5); exp_wb.push_back(32'd5);
    release_and_run(40);
    check_halted();
    check_gap("gap_nop", 2, 3, 3);
    check_gap("gap_beq_taken", 4, 5, 3);

    // beq not taken at 0x10
    start_test(0);
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h2002_0006;  // addi $2,$0,6
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h0000_0000;
    mem[4] = 32'h1022_0002;  // beq $1,$2,2
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_fetch(32'hC); exp_fetch(32'h10); exp_fetch(32'h14);
    exp_wb.push_back(32'd5); exp_wb.push_back(32'd6);
    release_and_run(40);
    check_halted();
    check_gap("gap_beq_not_taken", 4, 5, 3);

    // j 0x40 from PC 0
    start_test(0);
    mem[0] = 32'h0800_0010;
    exp_fetch(32'h0); exp_fetch(32'h40);
    release_and_run(20);
    check_halted();
    check_gap("gap_j", 0, 1, 2);

    // bne with $1 != $2 at PC 4
    start_test(0);
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h1422_0002;  // bne $1,$2,2
    exp_fetch(32'h0); exp_fetch(32'h4);
`ifdef BNE_EN
    exp_fetch(32'h10);
`endif
    exp_wb.push_back(32'd5);
    release_and_run(30);
    check_halted();

    // Reset asserted while a store waits in MEM
    start_test(3);
    mem[0] = 32'hAC02_0008;  // sw $2,8($0)
    mem[2] = 32'h1234_5678;
    exp_fetch(32'h0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      #1;
      if (mem_req && mem_we) found = 1'b1;
    end
    check(found, "mem_phase_reached", {31'd0, found}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check(mem_req == 1'b0, "abort_req", {31'd0, mem_req}, 32'd0);
    check(mem_we == 1'b0, "abort_we", {31'd0, mem_we}, 32'd0);
    mem[0] = ILL;
    exp_fetch(32'h0);
    repeat (2) @(negedge CLK);
    release_and_run(20);
    check_halted();
    check(mem[2] == 32'h1234_5678, "no_aborted_write", mem[2], 32'h1234_5678);

    // Final reset checks leftover expectations from the last test
    start_test(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
